pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/mdu_timer.sv | 74 +++++++
 rtl/pipe_ctrl.sv | 72 +++++++
 tb/tb_pipe_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// =============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared MDU op encodings, default latencies and FSM state type.
// Rev     : 1.0
// =============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam logic [1:0]  c_MDU_NONE     = 2'b00;
    localparam logic [1:0]  c_MDU_MULT     = 2'b01;
    localparam logic [1:0]  c_MDU_DIV      = 2'b10;

    localparam int unsigned c_MULT_LAT_DEF = 5;
    localparam int unsigned c_DIV_LAT_DEF  = 10;
    localparam int unsigned c_CNT_W        = 4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    // 2'b11 is reserved and never starts the unit.
    function automatic logic is_mdu_start_op(input logic [1:0] op);
        return (op == c_MDU_MULT) || (op == c_MDU_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_timer.sv
// =============================================================================
// Module  : mdu_timer
// Brief   : MDU busy countdown; accepts a start only when idle and no Req.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module mdu_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = c_MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = c_DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mdu_op,
    input  logic       req,
    output logic       start,
    output logic       busy,
    output logic       done
);

    localparam logic [c_CNT_W-1:0] c_MULT_LD = c_CNT_W'(MULT_LAT);
    localparam logic [c_CNT_W-1:0] c_DIV_LD  = c_CNT_W'(DIV_LAT);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    mdu_state_e         r_state;
    mdu_state_e         w_state_nxt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_start     = (r_state == S_IDLE) && is_mdu_start_op(mdu_op) && !req;
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_BUSY;
                    w_count_nxt = (mdu_op == c_MDU_MULT) ? c_MULT_LD : c_DIV_LD;
                end
            end
            S_BUSY: begin
                // Starts and Req are ignored here: the running op always finishes.
                w_count_nxt = r_count - c_ONE;
                if (r_count == c_ONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign start = w_start;
    assign busy  = (r_count != '0);
    assign done  = (r_count == c_ONE);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// =============================================================================
// Module  : pipe_ctrl
// Brief   : Pipeline stall/flush control with MDU busy tracking and stall counter.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = c_MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = c_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        d_stall_hzd,
    input  logic        d_uses_mdu,
    input  logic [1:0]  e_mdu_op,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cnt
);

    logic        w_stall;
    logic [31:0] r_stall_cnt;

    mdu_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_mdu_timer (
        .clk    (clk),
        .reset  (reset),
        .mdu_op (e_mdu_op),
        .req    (Req),
        .start  (mdu_start),
        .busy   (mdu_busy),
        .done   (mdu_done)
    );

    // An MDU user in ID must wait for a running op and for one starting in EX.
    assign w_stall = d_stall_hzd
                   | (d_uses_mdu & (mdu_busy | is_mdu_start_op(e_mdu_op)));

    // Req redirects fetch, so it wins over any stall and clears every stage.
    assign pc_en       = Req | ~w_stall;
    assign ifid_en     = Req | ~w_stall;
    assign ifid_flush  = Req;
    assign idex_flush  = Req | w_stall;
    assign exmem_flush = Req;
    assign memwb_flush = Req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !Req) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// =============================================================================
// Module  : tb_pipe_ctrl
// Brief   : Self-checking bench for pipe_ctrl: vectors, corner sequences, random.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam int c_MULT = 5;
    localparam int c_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset, Req, d_stall_hzd, d_uses_mdu;
    logic [1:0]  e_mdu_op;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        mdu_start, mdu_busy, mdu_done;
    logic [31:0] stall_cnt;

    pipe_ctrl #(.MULT_LAT(c_MULT), .DIV_LAT(c_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .Req         (Req),
        .d_stall_hzd (d_stall_hzd),
        .d_uses_mdu  (d_uses_mdu),
        .e_mdu_op    (e_mdu_op),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .memwb_flush (memwb_flush),
        .mdu_start   (mdu_start),
        .mdu_busy    (mdu_busy),
        .mdu_done    (mdu_done),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an MDU op started in cycle S with latency L is busy in
    // cycles S+1..S+L; the stall counter is a plain wrapping 32-bit count.
    int          m_cyc;
    int          m_start_cyc;
    int          m_lat;
    logic [31:0] m_cnt;

    // Values sampled at the most recent negedge, for hand-written checks.
    logic        s_pc, s_ifid, s_start, s_busy, s_done;
    logic [3:0]  s_fl;
    logic [31:0] s_cnt;

    typedef struct {
        logic        req;
        logic        hzd;
        logic        uses;
        logic [1:0]  op;
        logic        pc;
        logic        ifid;
        logic [3:0]  fl;
        logic        start;
        logic [31:0] inc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, m_cyc, act, exp);
        end
    endtask

    task automatic set_in(input logic rs, input logic rq, input logic hz, input logic us,
                          input logic [1:0] op);
        reset       = rs;
        Req         = rq;
        d_stall_hzd = hz;
        d_uses_mdu  = us;
        e_mdu_op    = op;
    endtask

    task automatic model_reset();
        m_lat       = 0;
        m_start_cyc = -1000;
        m_cnt       = '0;
    endtask

    // Runs one clock with the current inputs, comparing every output to the model.
    task automatic run_cycle();
        logic       m_busy, m_done, m_start, m_stall, m_op;
        logic [3:0] m_fl;
        @(negedge clk);
        m_op    = (e_mdu_op == 2'b01) || (e_mdu_op == 2'b10);
        m_busy  = (m_lat != 0) && (m_cyc > m_start_cyc) && (m_cyc <= m_start_cyc + m_lat);
        m_done  = m_busy && (m_cyc == m_start_cyc + m_lat);
        m_start = !m_busy && !Req && m_op;
        m_stall = d_stall_hzd || (d_uses_mdu && (m_busy || m_op));
        m_fl    = Req ? 4'b1111 : (m_stall ? 4'b0100 : 4'b0000);
        s_pc    = pc_en;
        s_ifid  = ifid_en;
        s_fl    = {ifid_flush, idex_flush, exmem_flush, memwb_flush};
        s_start = mdu_start;
        s_busy  = mdu_busy;
        s_done  = mdu_done;
        s_cnt   = stall_cnt;
        check("pc_en",     32'(s_pc),    32'(Req || !m_stall));
        check("ifid_en",   32'(s_ifid),  32'(Req || !m_stall));
        check("flushes",   32'(s_fl),    32'(m_fl));
        check("mdu_start", 32'(s_start), 32'(m_start));
        check("mdu_busy",  32'(s_busy),  32'(m_busy));
        check("mdu_done",  32'(s_done),  32'(m_done));
        check("stall_cnt", s_cnt,        m_cnt);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (m_start) begin
                m_start_cyc = m_cyc;
                m_lat       = (e_mdu_op == 2'b01) ? c_MULT : c_DIV;
            end
            if (m_stall && !Req) m_cnt = m_cnt + 32'd1;
        end
        m_cyc++;
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        run_cycle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", m_cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              req  hzd  uses op     pc   ifid fl       start inc
        vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0000, 1'b0, 32'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0100, 1'b0, 32'd1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 4'b0000, 1'b0, 32'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'b0100, 1'b1, 32'd1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 4'b0000, 1'b1, 32'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 4'b0000, 1'b0, 32'd0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 4'b1111, 1'b0, 32'd0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 4'b1111, 1'b0, 32'd0};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 4'b0100, 1'b1, 32'd1};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 4'b1111, 1'b0, 32'd0};

        m_cyc = 0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

        // Idle cycle straight after reset.
        run_cycle();
        check("rst_pc_en",  32'(s_pc),    32'd1);
        check("rst_ifid",   32'(s_ifid),  32'd1);
        check("rst_flush",  32'(s_fl),    32'd0);
        check("rst_busy",   32'(s_busy),  32'd0);
        check("rst_done",   32'(s_done),  32'd0);
        check("rst_start",  32'(s_start), 32'd0);
        check("rst_cnt",    s_cnt,        32'd0);

        // Single-cycle control vectors from idle, each followed by a reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, vecs[i].req, vecs[i].hzd, vecs[i].uses, vecs[i].op);
            run_cycle();
            check("vec_pc",    32'(s_pc),    32'(vecs[i].pc));
            check("vec_ifid",  32'(s_ifid),  32'(vecs[i].ifid));
            check("vec_flush", 32'(s_fl),    32'(vecs[i].fl));
            check("vec_start", 32'(s_start), 32'(vecs[i].start));
            do_reset();
            check("vec_cnt",   s_cnt,        vecs[i].inc);
        end

        // Mult start timeline.
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        run_cycle();
        check("mult_start_c0", 32'(s_start), 32'd1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int c = 1; c <= 6; c++) begin
            run_cycle();
            check("mult_busy", 32'(s_busy), 32'((c >= 1) && (c <= 5)));
            check("mult_done", 32'(s_done), 32'(c == 5));
        end

        // mfhi held in ID behind a div.
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        for (int c = 0; c <= 11; c++) begin
            run_cycle();
            check("mfhi_pc",   32'(s_pc),  32'(c > 10));
            check("mfhi_idex", 32'(s_fl[2]), 32'(c <= 10));
            e_mdu_op = 2'b00;
        end
        check("mfhi_cnt", s_cnt, 32'd11);

        // Req during a hazard.
        do_reset();
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        run_cycle();
        check("req_hzd_pc", 32'(s_pc), 32'd1);
        check("req_hzd_fl", 32'(s_fl), 32'hF);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        run_cycle();
        check("req_hzd_cnt", s_cnt, 32'd0);

        // Req with a div start, then Req and busy-time starts during a mult.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        run_cycle();
        check("req_div_start", 32'(s_start), 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        run_cycle();
        check("req_div_busy", 32'(s_busy), 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        for (int c = 0; c <= 6; c++) begin
            run_cycle();
            if (c == 4) check("busy_restart", 32'(s_start), 32'd0);
            if (c == 5) check("req_mult_done", 32'(s_done), 32'd1);
            if (c == 6) check("req_mult_idle", 32'(s_busy), 32'd0);
            set_in(1'b0, (c == 2), 1'b0, 1'b0, (c == 2) ? 2'b10 : ((c == 3) ? 2'b01 : 2'b00));
        end

        // Reset in cycle 2 of a div.
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        run_cycle();
        e_mdu_op = 2'b00;
        run_cycle();
        reset = 1'b1;
        run_cycle();
        check("rst_mid_pre_cnt", s_cnt, 32'd2);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        run_cycle();
        check("rst_mid_busy", 32'(s_busy), 32'd0);
        check("rst_mid_cnt",  s_cnt,       32'd0);

        // Stall counter wrap.
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        m_cnt = 32'hFFFF_FFFF;
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        run_cycle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        run_cycle();
        check("wrap_cnt", s_cnt, 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)));
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
